// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, bus-level constants and defaults.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    DEVADDR   = 4'd1,
    DEV_ACK   = 4'd2,
    REGADDR   = 4'd3,
    REG_ACK   = 4'd4,
    WR_BYTE   = 4'd5,
    WR_ACK    = 4'd6,
    RD_BYTE   = 4'd7,
    RD_ACK    = 4'd8,
    WAIT_STOP = 4'd9
  } state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam int unsigned BYTES_PER_WORD = 4;

  localparam logic [6:0] DEF_DEV_ADDR = 7'h63;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA conditioning: 2-flop synchronizers, one delay stage, and
// single-cycle SCL edge and START/STOP strobes. Shared with the master.
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda
);

  // [0] metastability flop, [1] synchronized level, [2] previous level
  logic [2:0] scl_p;
  logic [2:0] sda_p;

  // Shift both lines through the synchronizer/delay chain; idle bus is high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_p <= '1;
      sda_p <= '1;
    end else begin
      scl_p <= {scl_p[1:0], scl_in};
      sda_p <= {sda_p[1:0], sda_in};
    end
  end

  assign scl_rise = scl_p[1] & ~scl_p[2];
  assign scl_fall = ~scl_p[1] & scl_p[2];
  // SCL must be high in both samples so an SCL edge is never mistaken for START/STOP
  assign start    = scl_p[1] & scl_p[2] & ~sda_p[1] & sda_p[2];
  assign stop     = scl_p[1] & scl_p[2] & sda_p[1] & ~sda_p[2];
  assign sda      = sda_p[1];

endmodule

// File: rtl/i2c_slave.sv
// I2C target: fixed device address, one register-index byte, then one
// 32-bit word written or read as 4 bytes MSB first. Local register file
// is readable from the system side.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = DEF_DEV_ADDR,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned REG_AW   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  input  logic [REG_AW-1:0] host_addr,
  output logic [31:0]       host_rdata,
  output logic              wr_valid,
  output logic [REG_AW-1:0] wr_addr,
  output logic              busy
);

  localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);
  localparam logic [1:0] LAST_BYTE  = 2'(BYTES_PER_WORD - 1);

  logic scl_rise;
  logic scl_fall;
  logic start;
  logic stop;
  logic sda;

  state_t            state;
  logic [3:0]        bit_cnt;
  logic [1:0]        byte_cnt;
  logic [7:0]        shreg;
  logic              rw;
  logic [REG_AW-1:0] idx;
  logic [31:0]       stage;
  logic [31:0]       rd_shift;
  logic [1:0]        stage_pos;
  logic [31:0]       regs [NUM_REGS];

  i2c_line_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop),
    .sda      (sda)
  );

  assign stage_pos = LAST_BYTE - byte_cnt;
  assign busy      = (state != IDLE);

  // Protocol FSM: byte shifting, ACK driving, staging and register commit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      shreg    <= '0;
      rw       <= 1'b0;
      idx      <= '0;
      stage    <= '0;
      rd_shift <= '0;
      sda_oe   <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_valid <= 1'b0;
      if (start) begin
        state    <= DEVADDR;
        bit_cnt  <= '0;
        byte_cnt <= '0;
        stage    <= '0;
        sda_oe   <= 1'b0;
      end else if (stop) begin
        state    <= IDLE;
        bit_cnt  <= '0;
        byte_cnt <= '0;
        sda_oe   <= 1'b0;
      end else begin
        case (state)
          DEVADDR: begin
            if (scl_rise) begin
              shreg   <= {shreg[6:0], sda};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              if (shreg[7:1] == DEV_ADDR) begin
                rw     <= shreg[0];
                sda_oe <= 1'b1;
                state  <= DEV_ACK;
              end else begin
                state  <= WAIT_STOP;
              end
            end
          end
          DEV_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              state  <= REGADDR;
            end
          end
          REGADDR: begin
            if (scl_rise) begin
              shreg   <= {shreg[6:0], sda};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              if ({1'b0, shreg} < NUM_REGS_W) begin
                idx    <= shreg[REG_AW-1:0];
                sda_oe <= 1'b1;
                state  <= REG_ACK;
              end else begin
                state  <= WAIT_STOP;
              end
            end
          end
          REG_ACK: begin
            // For reads the first data bit goes out on the same falling
            // edge that ends the ACK slot, so the word is loaded here.
            if (scl_fall) begin
              byte_cnt <= '0;
              if (rw) begin
                rd_shift <= {regs[idx][30:0], 1'b0};
                sda_oe   <= ~regs[idx][31];
                state    <= RD_BYTE;
              end else begin
                sda_oe   <= 1'b0;
                state    <= WR_BYTE;
              end
            end
          end
          WR_BYTE: begin
            if (scl_rise) begin
              shreg   <= {shreg[6:0], sda};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt                       <= '0;
              stage[{stage_pos, 3'b000} +: 8] <= shreg;
              sda_oe                        <= 1'b1;
              state                         <= WR_ACK;
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              if (byte_cnt == LAST_BYTE) begin
                regs[idx] <= stage;
                wr_addr   <= idx;
                wr_valid  <= 1'b1;
                state     <= WAIT_STOP;
              end else begin
                byte_cnt  <= byte_cnt + 2'd1;
                state     <= WR_BYTE;
              end
            end
          end
          RD_BYTE: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                state   <= RD_ACK;
              end else begin
                sda_oe   <= ~rd_shift[31];
                rd_shift <= {rd_shift[30:0], 1'b0};
              end
            end
          end
          RD_ACK: begin
            // bit_cnt==1 marks "master ACKed, resume on the next falling edge"
            if (scl_rise) begin
              if (sda == NACK || byte_cnt == LAST_BYTE) begin
                state <= WAIT_STOP;
              end else begin
                byte_cnt <= byte_cnt + 2'd1;
                bit_cnt  <= 4'd1;
              end
            end else if (scl_fall && bit_cnt == 4'd1) begin
              bit_cnt  <= '0;
              sda_oe   <= ~rd_shift[31];
              rd_shift <= {rd_shift[30:0], 1'b0};
              state    <= RD_BYTE;
            end
          end
          WAIT_STOP: sda_oe <= 1'b0;
          IDLE:      sda_oe <= 1'b0;
          default: begin
            sda_oe <= 1'b0;
            state  <= IDLE;
          end
        endcase
      end
    end
  end

  // Registered host-side read port; a same-cycle commit shows up one cycle later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      host_rdata <= '0;
    end else begin
      host_rdata <= regs[host_addr];
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged master on a wired-AND SDA bus.
module tb_i2c_slave;

  localparam int Q = 4;  // clk cycles per quarter SCL period

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        master_scl = 1'b1;
  logic        master_sda = 1'b1;
  logic        scl_in;
  logic        sda_in;
  logic        sda_oe;
  logic [3:0]  host_addr = '0;
  logic [31:0] host_rdata;
  logic        wr_valid;
  logic [3:0]  wr_addr;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int wv_cnt   = 0;
  logic [3:0] wv_addr = '0;
  logic oe_seen = 1'b0;
  logic [31:0] model [16];

  assign scl_in = master_scl;
  assign sda_in = master_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave #(.DEV_ADDR(7'h63), .NUM_REGS(16), .REG_AW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .scl_in     (scl_in),
    .sda_in     (sda_in),
    .sda_oe     (sda_oe),
    .host_addr  (host_addr),
    .host_rdata (host_rdata),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .busy       (busy)
  );

  // Count commit pulses and remember the committed index
  always @(negedge clk) begin
    if (wr_valid) begin
      wv_cnt  = wv_cnt + 1;
      wv_addr = wr_addr;
    end
  end

  // Record any SDA drive by the target
  always @(negedge clk) begin
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_bit(input logic b, output logic r);
    master_sda = b;
    wait_q();
    master_scl = 1'b1;
    wait_q();
    r = sda_in;
    wait_q();
    master_scl = 1'b0;
    wait_q();
  endtask

  task automatic i2c_start();
    master_sda = 1'b1;
    master_scl = 1'b1;
    wait_q();
    master_sda = 1'b0;
    wait_q();
    master_scl = 1'b0;
    wait_q();
  endtask

  task automatic i2c_stop();
    master_sda = 1'b0;
    wait_q();
    master_scl = 1'b1;
    wait_q();
    master_sda = 1'b1;
    wait_q();
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], r);
    bus_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, r);
      d[i] = r;
    end
    bus_bit(mack, r);
  endtask

  // Full write transaction; acks[5] is the device-address slot
  task automatic write_txn(input logic [6:0] dev, input logic [7:0] ra,
                           input logic [31:0] data, output logic [5:0] acks);
    i2c_start();
    send_byte({dev, 1'b0}, acks[5]);
    send_byte(ra, acks[4]);
    send_byte(data[31:24], acks[3]);
    send_byte(data[23:16], acks[2]);
    send_byte(data[15:8], acks[1]);
    send_byte(data[7:0], acks[0]);
    i2c_stop();
  endtask

  task automatic host_read(input logic [3:0] a, output logic [31:0] d);
    host_addr = a;
    @(negedge clk);
    d = host_rdata;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  acks;
    logic        a;
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] d;
    int          wv0;

    for (int i = 0; i < 16; i++) model[i] = '0;

    repeat (3) @(negedge clk);
    check("reset_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_wr_valid", {31'd0, wr_valid}, 32'd0);
    check("reset_wr_addr", {28'd0, wr_addr}, 32'd0);
    check("reset_host_rdata", host_rdata, 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Basic write to reg 0x0B
    wv0 = wv_cnt;
    write_txn(7'h63, 8'h0B, 32'h58AE1234, acks);
    model[11] = 32'h58AE1234;
    check("wr_b_acks", {26'd0, acks}, 32'd0);
    check("wr_b_wv_cnt", wv_cnt - wv0, 32'd1);
    check("wr_b_wr_addr", {28'd0, wv_addr}, 32'hB);
    check("wr_b_busy_idle", {31'd0, busy}, 32'd0);
    host_read(4'hB, d);
    check("wr_b_host_rdata", d, 32'h58AE1234);

    // Preload reg 0x0F, then read it back over the bus
    write_txn(7'h63, 8'h0F, 32'h583412AE, acks);
    model[15] = 32'h583412AE;
    check("wr_f_acks", {26'd0, acks}, 32'd0);
    i2c_start();
    send_byte({7'h63, 1'b1}, a);
    check("rd_dev_ack", {31'd0, a}, 32'd0);
    send_byte(8'h0F, a);
    check("rd_reg_ack", {31'd0, a}, 32'd0);
    read_byte(1'b0, b0);
    read_byte(1'b0, b1);
    read_byte(1'b0, b2);
    read_byte(1'b1, b3);
    check("rd_byte0", {24'd0, b0}, 32'h58);
    check("rd_byte1", {24'd0, b1}, 32'h34);
    check("rd_byte2", {24'd0, b2}, 32'h12);
    check("rd_byte3", {24'd0, b3}, 32'hAE);
    check("rd_release", {31'd0, sda_oe}, 32'd0);
    i2c_stop();

    // Wrong device address: no ACK, no drive, no commit
    wv0 = wv_cnt;
    oe_seen = 1'b0;
    write_txn(7'h6B, 8'hBF, 32'h123458AE, acks);
    check("bad_dev_acks", {26'd0, acks}, 32'h3F);
    check("bad_dev_oe_seen", {31'd0, oe_seen}, 32'd0);
    check("bad_dev_wv", wv_cnt - wv0, 32'd0);
    for (int i = 0; i < 16; i++) begin
      host_read(4'(i), d);
      check($sformatf("bad_dev_reg%0d", i), d, model[i]);
    end

    // Out-of-range register index: device ACK, register NACK, data ignored
    wv0 = wv_cnt;
    write_txn(7'h63, 8'hFB, 32'hDEADBEEF, acks);
    check("bad_reg_acks", {26'd0, acks}, 32'h1F);
    check("bad_reg_wv", wv_cnt - wv0, 32'd0);

    // STOP after two data bytes discards the partial word
    write_txn(7'h63, 8'h03, 32'hCAFEF00D, acks);
    model[3] = 32'hCAFEF00D;
    check("wr_3_acks", {26'd0, acks}, 32'd0);
    wv0 = wv_cnt;
    i2c_start();
    send_byte({7'h63, 1'b0}, a);
    send_byte(8'h03, a);
    send_byte(8'h11, a);
    send_byte(8'h22, a);
    check("part_byte2_ack", {31'd0, a}, 32'd0);
    master_sda = 1'b0;
    wait_q();
    master_scl = 1'b1;
    wait_q();
    master_sda = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("part_busy_2clk", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    check("part_busy_3clk", {31'd0, busy}, 32'd0);
    @(negedge clk);
    wait_q();
    check("part_wv", wv_cnt - wv0, 32'd0);
    host_read(4'h3, d);
    check("part_reg3", d, 32'hCAFEF00D);

    // Asynchronous reset while the target drives SDA during a read
    i2c_start();
    send_byte({7'h63, 1'b1}, a);
    send_byte(8'h0F, a);
    check("rst_mid_oe_before", {31'd0, sda_oe}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid_oe_after", {31'd0, sda_oe}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 16; i++) model[i] = '0;
    @(negedge clk);
    rst = 1'b1;
    master_sda = 1'b1;
    wait_q();
    master_scl = 1'b1;
    wait_q();
    host_read(4'hF, d);
    check("post_rst_reg15", d, 32'd0);
    wv0 = wv_cnt;
    write_txn(7'h63, 8'h05, 32'h0BADBEEF, acks);
    check("post_rst_acks", {26'd0, acks}, 32'd0);
    check("post_rst_wv", wv_cnt - wv0, 32'd1);
    check("post_rst_wr_addr", {28'd0, wr_addr}, 32'h5);
    host_read(4'h5, d);
    check("post_rst_reg5", d, 32'h0BADBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
